mem_lane_initiator: RTL and testbench

- Core-side initiator for the 8-lane shared data memory. The memory has one shared write strobe and one shared read strobe across all lanes, plus per-lane address and data.
- Collects per-core load/store requests (valid/ready) and groups them into single-kind batches: all-write or all-read.
- Drives the memory lane buses, parks unused lanes, and returns per-lane completions and read data.
- Sits between the 8 processor cores and the data memory.

---
 rtl/mem_if_pkg.sv | 36 +++
 rtl/mem_lane_initiator_batch_select.sv | 34 +++
 rtl/mem_lane_initiator.sv | 167 ++++++++++++++++
 tb/tb_mem_lane_initiator.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the memory lane initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_if_pkg;

    localparam int LANES = 8;
    localparam int AW    = 16;
    localparam int DW    = 16;

    // Lies above the memory's writable bound, so a parked lane can never
    // change memory even while the shared write strobe is high.
    localparam logic [AW-1:0] PARK_ADDR = 16'hFFFF;

    // Word offsets of the matrix header held in data memory.
    localparam int HDR_A_ROWS = 1;
    localparam int HDR_A_COLS = 2;
    localparam int HDR_B_ROWS = 3;
    localparam int HDR_B_COLS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of lanes taking part in a batch.
    function automatic logic [31:0] lane_count(input logic [LANES-1:0] m);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + 32'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_initiator_batch_select.sv
// Purpose: pick the kind (write/read) of the next batch and the lanes that join it.
// Latency: purely combinational.
// Backpressure: none; lanes of the losing kind are simply left out of the mask.
//
// Ports:
//   valid    - per-lane request valid
//   we       - per-lane kind, 1 = write, 0 = read
//   prefer_w - tie-break when both kinds are pending
//   kind     - chosen batch kind, 1 = write
//   mask     - lanes taking part in the chosen batch
//   pending  - at least one request of either kind is present
module batch_select
    import mem_if_pkg::*;
(
    input  logic [LANES-1:0] valid,
    input  logic [LANES-1:0] we,
    input  logic             prefer_w,
    output logic             kind,
    output logic [LANES-1:0] mask,
    output logic             pending
);

    logic pend_w;
    logic pend_r;

    always_comb begin
        pend_w  = |(valid & we);
        pend_r  = |(valid & ~we);
        pending = pend_w | pend_r;
        kind    = pend_w && (!pend_r || prefer_w);
        mask    = valid & (kind ? we : ~we);
    end

endmodule

// File: rtl/mem_lane_initiator.sv
// Purpose: group per-core load/store requests into single-kind batches for the 8-lane shared memory.
// Latency: accept at T, strobe at T+1, completion pulse (and read data) at T+2; one batch per 3 cycles.
// Backpressure: req_ready only in IDLE for lanes of the chosen kind; others stay pending for the next batch.
//
// Optional build macro MEM_INIT_STATS_EN adds batch/lane-operation counters.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/we/addr/wdata    - per-lane requests (lane i at [i*W +: W])
//   req_ready                  - per-lane accept, combinational, IDLE only
//   rsp_valid, rsp_rdata       - per-lane completion pulse and read data
//   mem_write, mem_read        - shared memory strobes (one cycle per batch)
//   mem_addr, mem_wdata        - memory lane buses, unused lanes parked
//   mem_rdata                  - memory lane read data, one cycle after mem_read
//   stat_*                     - batch and lane-operation counters (MEM_INIT_STATS_EN only)
module mem_lane_initiator
    import mem_if_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES-1:0]    req_valid,
    input  logic [LANES-1:0]    req_we,
    input  logic [LANES*AW-1:0] req_addr,
    input  logic [LANES*DW-1:0] req_wdata,
    output logic [LANES-1:0]    req_ready,
    output logic [LANES-1:0]    rsp_valid,
    output logic [LANES*DW-1:0] rsp_rdata,
    output logic                mem_write,
    output logic                mem_read,
    output logic [LANES*AW-1:0] mem_addr,
    output logic [LANES*DW-1:0] mem_wdata,
    input  logic [LANES*DW-1:0] mem_rdata
`ifdef MEM_INIT_STATS_EN
    ,
    output logic [31:0]         stat_wr_batches,
    output logic [31:0]         stat_rd_batches,
    output logic [31:0]         stat_lane_ops
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [LANES-1:0] mask_q;
    logic             kind_q;
    logic             prefer_w_q;

    logic             sel_kind;
    logic [LANES-1:0] sel_mask;
    logic             sel_pending;

    batch_select u_sel (
        .valid    (req_valid),
        .we       (req_we),
        .prefer_w (prefer_w_q),
        .kind     (sel_kind),
        .mask     (sel_mask),
        .pending  (sel_pending)
    );

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_pending) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM outputs (combinational)
    // ---------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        case (state_q)
            // No handshake is offered while reset is held.
            IDLE: if (rst_n) req_ready = sel_mask;
            DONE: begin
                rsp_valid = mask_q;
                for (int i = 0; i < LANES; i++) begin
                    if (mask_q[i] && !kind_q) begin
                        rsp_rdata[i*DW +: DW] = mem_rdata[i*DW +: DW];
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Batch capture and memory lane drive. The strobes come straight
    // from flops with async reset, so asserting rst_n during ISSUE
    // drops them before the edge that would commit the write.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            kind_q     <= 1'b0;
            prefer_w_q <= 1'b1;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= {LANES{PARK_ADDR}};
            mem_wdata  <= '0;
        end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_pending) begin
                        mask_q    <= sel_mask;
                        kind_q    <= sel_kind;
                        mem_write <= sel_kind;
                        mem_read  <= !sel_kind;
                        for (int i = 0; i < LANES; i++) begin
                            mem_addr[i*AW +: AW]  <= sel_mask[i] ? req_addr[i*AW +: AW]  : PARK_ADDR;
                            mem_wdata[i*DW +: DW] <= sel_mask[i] ? req_wdata[i*DW +: DW] : '0;
                        end
                    end
                end
                ISSUE: begin
                    // Flip the tie-break so both kinds alternate under contention.
                    prefer_w_q <= !kind_q;
                end
                DONE: begin
                    mask_q    <= '0;
                    mem_addr  <= {LANES{PARK_ADDR}};
                    mem_wdata <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_INIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_batches <= '0;
            stat_rd_batches <= '0;
            stat_lane_ops   <= '0;
        end else if (state_q == ISSUE) begin
            if (kind_q) begin
                stat_wr_batches <= stat_wr_batches + 32'd1;
            end else begin
                stat_rd_batches <= stat_rd_batches + 32'd1;
            end
            stat_lane_ops <= stat_lane_ops + lane_count(mask_q);
        end
    end
`endif

endmodule

// File: tb/tb_mem_lane_initiator.sv
`timescale 1ns/1ps
module tb_mem_lane_initiator;
    import mem_if_pkg::*;

    localparam int MEM_WORDS = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [LANES-1:0]    req_valid;
    logic [LANES-1:0]    req_we;
    logic [LANES*AW-1:0] req_addr;
    logic [LANES*DW-1:0] req_wdata;
    logic [LANES-1:0]    req_ready;
    logic [LANES-1:0]    rsp_valid;
    logic [LANES*DW-1:0] rsp_rdata;
    logic                mem_write;
    logic                mem_read;
    logic [LANES*AW-1:0] mem_addr;
    logic [LANES*DW-1:0] mem_wdata;
    logic [LANES*DW-1:0] mem_rdata = '0;
`ifdef MEM_INIT_STATS_EN
    logic [31:0] stat_wr_batches, stat_rd_batches, stat_lane_ops;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [LANES*AW-1:0] park_all;
    logic [DW-1:0]       tb_mem [MEM_WORDS];

    typedef struct {
        logic [LANES-1:0]    mask;
        logic [LANES*DW-1:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    mem_lane_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_INIT_STATS_EN
        ,
        .stat_wr_batches (stat_wr_batches),
        .stat_rd_batches (stat_rd_batches),
        .stat_lane_ops   (stat_lane_ops)
`endif
    );

    // Standalone instance of the selector.
    logic [LANES-1:0] bs_valid, bs_we, bs_mask;
    logic             bs_prefer_w, bs_kind, bs_pending;
    batch_select u_bs (
        .valid    (bs_valid),
        .we       (bs_we),
        .prefer_w (bs_prefer_w),
        .kind     (bs_kind),
        .mask     (bs_mask),
        .pending  (bs_pending)
    );

    // Data memory model: writable below MEM_WORDS, lanes applied in order so
    // the highest-numbered lane wins; read data registered.
    always @(posedge clk) begin
        logic [AW-1:0] a;
        for (int i = 0; i < LANES; i++) begin
            a = mem_addr[i*AW +: AW];
            if (mem_write && a < AW'(MEM_WORDS)) tb_mem[a[5:0]] = mem_wdata[i*DW +: DW];
            if (mem_read) mem_rdata[i*DW +: DW] <= (a < AW'(MEM_WORDS)) ? tb_mem[a[5:0]] : 16'hDEAD;
        end
    end

    // Scoreboard: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid != '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: rsp_valid=%h rdata=%h, want no response", rsp_valid, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_valid !== e.mask || rsp_rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL rsp_scoreboard: got valid=%h rdata=%h, want valid=%h rdata=%h",
                             rsp_valid, rsp_rdata, e.mask, e.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_lane(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Writes one word through the DUT (lane 0) to set up memory contents.
    task automatic preload_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{mask: 8'h01, rdata: '0});
        clear_req();
        set_lane(0, 1'b1, a, d);
        step(); clear_req();
        step(); step();
    endtask

    task automatic test_reset();
        clear_req();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_addr !== park_all) begin n_bad++; $display("FAIL rst_mem_addr: got %h want %h", mem_addr, park_all); end
        n_cmp++; if (mem_wdata !== '0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rst_req_ready: got %h want 0", req_ready); end
        n_cmp++; if (rsp_valid !== '0 || rsp_rdata !== '0) begin n_bad++; $display("FAIL rst_rsp: got %h/%h want 0/0", rsp_valid, rsp_rdata); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_batch_select();
        // {valid, we, prefer_w, kind, mask, pending}
        logic [LANES-1:0] tv [5], tw [5], tm [5];
        logic             tp [5], tk [5], tn [5];
        tv = '{8'h00, 8'h0F, 8'h0F, 8'h0C, 8'hF0};
        tw = '{8'h00, 8'h03, 8'h03, 8'h03, 8'hF0};
        tp = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        tk = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        tm = '{8'h00, 8'h03, 8'h0C, 8'h0C, 8'hF0};
        tn = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
        for (int i = 0; i < 5; i++) begin
            bs_valid = tv[i]; bs_we = tw[i]; bs_prefer_w = tp[i];
            #1;
            n_cmp++;
            if (bs_pending !== tn[i] || bs_mask !== tm[i] || (tn[i] && bs_kind !== tk[i])) begin
                n_bad++;
                $display("FAIL batch_select[%0d]: got pending=%b kind=%b mask=%h want pending=%b kind=%b mask=%h",
                         i, bs_pending, bs_kind, bs_mask, tn[i], tk[i], tm[i]);
            end
        end
    endtask

    task automatic test_single_read();
        logic [LANES*DW-1:0] r;
        logic [LANES*AW-1:0] ea;
        preload_word(16'd5, 16'h0007);
        r = '0; r[3*DW +: DW] = 16'h0007;
        ea = park_all; ea[3*AW +: AW] = 16'd5;
        exp_q.push_back('{mask: 8'h08, rdata: r});
        clear_req();
        set_lane(3, 1'b0, 16'd5, '0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'h08) begin n_bad++; $display("FAIL rd_ready: got %h want 08", req_ready); end
        step(); clear_req();
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_bad++; $display("FAIL rd_strobe: got rd=%b wr=%b want rd=1 wr=0", mem_read, mem_write); end
        n_cmp++; if (mem_addr !== ea) begin n_bad++; $display("FAIL rd_addr: got %h want %h", mem_addr, ea); end
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 8'h08) begin n_bad++; $display("FAIL rd_rsp_time: got %h want 08", rsp_valid); end
        step();
    endtask

    task automatic test_full_write();
        logic [LANES*DW-1:0] r;
        r = '0;
        clear_req();
        for (int i = 0; i < LANES; i++) begin
            set_lane(i, 1'b1, AW'(10 + i), DW'(16'hA0 + i));
            r[i*DW +: DW] = DW'(16'hA0 + i);
        end
        exp_q.push_back('{mask: 8'hFF, rdata: '0});
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'hFF) begin n_bad++; $display("FAIL fw_ready: got %h want ff", req_ready); end
        step(); clear_req();
        @(negedge clk);
        n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_bad++; $display("FAIL fw_strobe: got wr=%b rd=%b want wr=1 rd=0", mem_write, mem_read); end
        step();
        @(negedge clk);
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL fw_single_pulse: got %b want 0", mem_write); end
        step();
        exp_q.push_back('{mask: 8'hFF, rdata: r});
        for (int i = 0; i < LANES; i++) set_lane(i, 1'b0, AW'(10 + i), '0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'hFF) begin n_bad++; $display("FAIL fr_ready: got %h want ff", req_ready); end
        step(); clear_req();
        step(); step();
    endtask

    task automatic test_mixed();
        logic [LANES*DW-1:0] r;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        r = '0; r[2*DW +: DW] = 16'h00A0; r[3*DW +: DW] = 16'h00A1;
        exp_q.push_back('{mask: 8'h03, rdata: '0});
        exp_q.push_back('{mask: 8'h0C, rdata: r});
        clear_req();
        set_lane(0, 1'b1, 16'd40, 16'h1234);
        set_lane(1, 1'b1, 16'd41, 16'h5678);
        set_lane(2, 1'b0, 16'd10, '0);
        set_lane(3, 1'b0, 16'd11, '0);
        @(negedge clk);   // T
        n_cmp++; if (req_ready !== 8'h03) begin n_bad++; $display("FAIL mix_w_ready: got %h want 03", req_ready); end
        step();
        req_valid[1:0] = 2'b00; req_we = '0;
        @(negedge clk);   // T+1
        n_cmp++; if (req_ready !== 8'h00 || mem_write !== 1'b1) begin n_bad++; $display("FAIL mix_issue: got ready=%h wr=%b want 00/1", req_ready, mem_write); end
        step();
        @(negedge clk);   // T+2
        n_cmp++; if (rsp_valid !== 8'h03) begin n_bad++; $display("FAIL mix_w_rsp: got %h want 03", rsp_valid); end
        step();
        @(negedge clk);   // T+3
        n_cmp++; if (req_ready !== 8'h0C) begin n_bad++; $display("FAIL mix_r_ready: got %h want 0c", req_ready); end
        step(); clear_req();
        step();
        @(negedge clk);   // T+5
        n_cmp++; if (rsp_valid !== 8'h0C) begin n_bad++; $display("FAIL mix_r_rsp: got %h want 0c", rsp_valid); end
        step();
    endtask

    task automatic test_alternation();
        int            acc = 0;
        int            since [2];
        logic [DW-1:0] wr_data, last_wr;
        logic [LANES*DW-1:0] r;
        logic          lane0_taken;
        since[0] = 0; since[1] = 0;
        wr_data = 16'hC000; last_wr = 16'h0000;
        clear_req();
        set_lane(0, 1'b1, 16'd50, wr_data);
        set_lane(1, 1'b0, 16'd50, '0);
        for (int cyc = 0; cyc < 30 && acc < 4; cyc++) begin
            lane0_taken = 1'b0;
            @(negedge clk);
            if (req_ready != '0) begin
                n_cmp++;
                if (req_ready !== ((acc % 2 == 0) ? 8'h01 : 8'h02)) begin
                    n_bad++;
                    $display("FAIL alt_kind[%0d]: got ready=%h want %h", acc, req_ready, (acc % 2 == 0) ? 8'h01 : 8'h02);
                end
                for (int l = 0; l < 2; l++) begin
                    if (req_ready[l]) begin
                        n_cmp++;
                        if (cyc - since[l] > 6) begin
                            n_bad++;
                            $display("FAIL alt_wait lane%0d: got %0d cycles want <= 6", l, cyc - since[l]);
                        end
                        since[l] = cyc;
                    end
                end
                if (req_ready == 8'h01) begin
                    exp_q.push_back('{mask: 8'h01, rdata: '0});
                    last_wr = wr_data;
                    lane0_taken = 1'b1;
                end else if (req_ready == 8'h02) begin
                    r = '0; r[DW +: DW] = last_wr;
                    exp_q.push_back('{mask: 8'h02, rdata: r});
                end
                acc++;
            end
            step();
            if (lane0_taken) begin
                wr_data = wr_data + 16'd1;
                req_wdata[0 +: DW] = wr_data;
            end
        end
        n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL alt_count: got %0d batches want 4", acc); end
        clear_req();
        step(); step();
    endtask

    task automatic test_duplicate();
        logic [LANES*DW-1:0] r;
        clear_req();
        set_lane(2, 1'b1, 16'd20, 16'h1111);
        set_lane(6, 1'b1, 16'd20, 16'h6666);
        exp_q.push_back('{mask: 8'h44, rdata: '0});
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'h44) begin n_bad++; $display("FAIL dup_w_ready: got %h want 44", req_ready); end
        step(); clear_req(); step(); step();
        r = '0; r[0 +: DW] = 16'h6666; r[5*DW +: DW] = 16'h6666;
        exp_q.push_back('{mask: 8'h21, rdata: r});
        set_lane(0, 1'b0, 16'd20, '0);
        set_lane(5, 1'b0, 16'd20, '0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'h21) begin n_bad++; $display("FAIL dup_r_ready: got %h want 21", req_ready); end
        step(); clear_req(); step(); step();
    endtask

    task automatic test_out_of_range();
        clear_req();
        set_lane(4, 1'b1, 16'h0100, 16'hBAD0);
        exp_q.push_back('{mask: 8'h10, rdata: '0});
        step(); clear_req(); step(); step();
    endtask

    task automatic test_reset_mid_issue();
        preload_word(16'd30, 16'h0055);
        clear_req();
        set_lane(0, 1'b1, 16'd30, 16'hBEEF);
        @(negedge clk);
        n_cmp++; if (req_ready !== 8'h01) begin n_bad++; $display("FAIL rmi_ready: got %h want 01", req_ready); end
        step(); clear_req();
        #1;
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rmi_issue: got wr=%b want 1", mem_write); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rmi_async_drop: got wr=%b want 0", mem_write); end
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0 || mem_addr !== park_all || mem_wdata !== '0) begin
            n_bad++; $display("FAIL rmi_mem_bus: got rd=%b addr=%h wdata=%h want 0/%h/0", mem_read, mem_addr, mem_wdata, park_all);
        end
        n_cmp++; if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0) begin
            n_bad++; $display("FAIL rmi_outputs: got ready=%h rsp=%h rdata=%h want 0", req_ready, rsp_valid, rsp_rdata);
        end
        step();
        n_cmp++; if (tb_mem[30] !== 16'h0055) begin n_bad++; $display("FAIL rmi_word30: got %h want 0055", tb_mem[30]); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rmi_no_rsp[%0d]: got %h want 0", i, rsp_valid); end
            step();
        end
        n_cmp++; if (tb_mem[30] !== 16'h0055) begin n_bad++; $display("FAIL rmi_word30_late: got %h want 0055", tb_mem[30]); end
    endtask

    initial begin
        park_all = {LANES{PARK_ADDR}};
        test_reset();
        test_batch_select();
        test_single_read();
        test_full_write();
        test_mixed();
        test_alternation();
        test_duplicate();
        test_out_of_range();
        test_reset_mid_issue();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rsp_missing: got %0d outstanding expectations want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
